// File: rtl/scenario_sequencer.sv
// Stimulus sequencer feeding `top`: issues a start pulse and scenario code for one
// selected scenario or the whole regression list, each bounded by a completion window.
module scenario_sequencer #(
  parameter int unsigned DEL_CYCLES   = 50,
  parameter int unsigned BURSTN       = 16,
  parameter int unsigned START_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       go,
  input  logic       run_all,
  input  logic [4:0] scen_sel,
  input  logic       bus_done,
  output logic       start,
  output logic [4:0] state_out,
  output logic       busy,
  output logic       scen_done,
  output logic       timeout,
  output logic       err
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP} state_e;

  localparam int unsigned SLOT_CYCLES = DEL_CYCLES * BURSTN;
  localparam logic [3:0]  LAST_IDX    = 4'd8;
  localparam logic [15:0] START_LAST  = 16'(START_CYCLES - 1);

  // Window weight per scenario code; zero marks an invalid code.
  function automatic logic [2:0] weight_of(input logic [4:0] code);
    case (code)
      5'd0:                               weight_of = 3'd1;
      5'd2, 5'd3, 5'd5, 5'd7, 5'd8, 5'd9: weight_of = 3'd2;
      5'd6:                               weight_of = 3'd3;
      5'd4:                               weight_of = 3'd4;
      default:                            weight_of = 3'd0;
    endcase
  endfunction

  // Regression list is 0,2,3,...,9: every entry after the first skips code 1.
  function automatic logic [4:0] list_code(input logic [3:0] idx);
    list_code = (idx == 4'd0) ? 5'd0 : 5'(idx) + 5'd1;
  endfunction

  state_e      state_q, state_d;
  logic        go_q;
  logic        run_all_q, run_all_d;
  logic [4:0]  sel_q, sel_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] limit_q, limit_d;
  logic        start_q, start_d;
  logic [4:0]  state_out_q, state_out_d;
  logic        busy_q, busy_d;
  logic        scen_done_q, scen_done_d;
  logic        timeout_q, timeout_d;
  logic        err_q, err_d;

  logic        go_rise;
  logic [4:0]  code_w;

  assign go_rise = go & ~go_q;
  assign code_w  = run_all_q ? list_code(idx_q) : sel_q;

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    run_all_d   = run_all_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    state_out_d = state_out_q;
    timeout_d   = timeout_q;
    start_d     = 1'b0;
    scen_done_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go_rise) begin
          if (run_all) begin
            run_all_d = 1'b1;
            idx_d     = 4'd0;
            timeout_d = 1'b0;
            state_d   = S_LOAD;
          end else if (weight_of(scen_sel) != 3'd0) begin
            run_all_d = 1'b0;
            sel_d     = scen_sel;
            timeout_d = 1'b0;
            state_d   = S_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        state_out_d = code_w;
        limit_d     = 16'(32'(weight_of(code_w)) * SLOT_CYCLES);
        cnt_d       = 16'd0;
        start_d     = 1'b1;
        state_d     = S_START;
      end
      S_START: begin
        if (cnt_q == START_LAST) begin
          cnt_d   = 16'd0;
          state_d = S_WAIT;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          start_d = 1'b1;
        end
      end
      S_WAIT: begin
        // A done arriving on the final count still counts as completion.
        if (bus_done || (cnt_q == limit_q - 16'd1)) begin
          cnt_d       = 16'd0;
          scen_done_d = 1'b1;
          if (!bus_done) timeout_d = 1'b1;
          state_d     = S_GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_GAP: begin
        if (run_all_q && (idx_q != LAST_IDX)) begin
          idx_d   = idx_q + 4'd1;
          state_d = S_LOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      go_q        <= 1'b0;
      run_all_q   <= 1'b0;
      sel_q       <= 5'd0;
      idx_q       <= 4'd0;
      cnt_q       <= 16'd0;
      limit_q     <= 16'd0;
      start_q     <= 1'b0;
      state_out_q <= 5'd0;
      busy_q      <= 1'b0;
      scen_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      go_q        <= go;
      run_all_q   <= run_all_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      limit_q     <= limit_d;
      start_q     <= start_d;
      state_out_q <= state_out_d;
      busy_q      <= busy_d;
      scen_done_q <= scen_done_d;
      timeout_q   <= timeout_d;
      err_q       <= err_d;
    end
  end

  assign start     = start_q;
  assign state_out = state_out_q;
  assign busy      = busy_q;
  assign scen_done = scen_done_q;
  assign timeout   = timeout_q;
  assign err       = err_q;

endmodule

// File: doc/scenario_sequencer.md
# scenario_sequencer

Hardware replacement for the bench-driven stimulus into `top`. It produces the `start` pulse and 5-bit `state_in` scenario code that `top` consumes, either for one selected bus scenario or for the full regression list in order. Each scenario gets a fixed completion window, which can end early on a done indication from the bus. It sits directly upstream of `top` on the FPGA, driven by board switches and a debounced push-button.

## Interface
Parameters:
- `DEL_CYCLES`, default 50: clock cycles per transfer slot (1000 ns at 50 MHz).
- `BURSTN`, default 16: transfers per burst.
- `START_CYCLES`, default 2: width of the `start` pulse in cycles.

Ports:
- `clk` in 1: single system clock.
- `reset` in 1: synchronous, active-high reset.
- `go` in 1: request, sampled in IDLE. Must be a one-cycle pulse or a level; only the rising edge acts.
- `run_all` in 1: sampled with `go`. 1 = run the full list, 0 = run `scen_sel` only.
- `scen_sel` in 5: scenario code used in single mode.
- `bus_done` in 1: optional completion from `top`. Tie to 0 if unused.
- `start` out 1: start pulse to `top`.
- `state_out` out 5: scenario code, wired to `top.state_in`.
- `busy` out 1: high in every state except IDLE.
- `scen_done` out 1: one-cycle pulse at the end of each scenario's window.
- `timeout` out 1: sticky flag.
- `err` out 1: one-cycle pulse when `go` targets an invalid code.

## Operation
Scenario codes, each with its window weight W:
- 0: M1 write S2, W=1.
- 2: M1 read S2 / M2 write, W=2.
- 3: M1 read S2, M2 write S1, W=2.
- 4: M1+M2 read S2, W=4.
- 5: M1+M2 write S2, W=2.
- 6: M2 read S2, M1 read S1, W=3.
- 7: M1 write S1, M2 read S1, W=2.
- 8: M1 read, M2 write S1, W=2.
- 9: M1 write S2, M2 write S1, W=2.
- Codes 1 and 10–31 are invalid.

Run-all list, in order: 0, 2, 3, 4, 5, 6, 7, 8, 9.

FSM states: IDLE, LOAD, START, WAIT, GAP.

IDLE:
- On a `go` rising edge with `run_all`=1: index ← 0, go to LOAD.
- On a `go` rising edge with `run_all`=0 and a valid `scen_sel`: capture `scen_sel`, go to LOAD.
- On a `go` rising edge with `run_all`=0 and an invalid `scen_sel`: pulse `err`, stay in IDLE.
- Any accepted `go` clears `timeout`.

LOAD (1 cycle):
- Drive `state_out` with the code.
- Compute limit = W·DEL_CYCLES·BURSTN into a 16-bit register. Max 4·50·16 = 3200.
- A parameter product that overflows 16 bits is a configuration error; no runtime check.

START:
- `start`=1 for exactly START_CYCLES cycles.

WAIT:
- Counter starts at 0 and increments every cycle.
- Exit to GAP when `bus_done`=1, or when counter = limit−1.
- If it exits on the count without `bus_done`, set `timeout`.
- `bus_done` and count expiry in the same cycle count as done; `timeout` is not set.

GAP (1 cycle):
- Pulse `scen_done`.
- Single mode: go to IDLE.
- Run-all mode: advance the index and go to LOAD; after the last entry (index 8), go to IDLE.

Further rules:
- `go` outside IDLE is ignored.
- `bus_done` outside WAIT is ignored.

## Timing
Reset values:
- State IDLE.
- `start`=0, `state_out`=0, `busy`=0, `scen_done`=0, `timeout`=0, `err`=0.
- Counter and index are 0.

Reset mid-operation: on the next edge, all outputs return to their reset values and `start` drops immediately; no `scen_done` is emitted.

Cycle timing, with edge E = the cycle where `go` is sampled high in IDLE:
- LOAD at E+1; `busy` high from E+1.
- `start` high E+2 to E+1+START_CYCLES.
- `state_out` is stable from E+2 until the next LOAD, and is held after the return to IDLE.
- WAIT's first cycle is E+2+START_CYCLES.
- Timeout path: `scen_done` at E+2+START_CYCLES+limit; `busy` falls the following cycle.
- Run-all: the next LOAD is the cycle after GAP.

All outputs are registered.

## Test plan
- Single scenario 0, defaults: `go` pulse with `scen_sel`=0 → `start` high for 2 cycles starting E+2, `state_out`=0, `scen_done` at E+804, `timeout`=1, `busy` 0 at E+805.
- Early done: scenario 4 with `bus_done` pulsed 100 cycles into WAIT → `scen_done` on the next cycle, `timeout`=0, no further `start`.
- Run-all, `bus_done` tied 0 → `state_out` steps 0,2,3,4,5,6,7,8,9; 9 `start` pulses; 9 `scen_done` pulses; total windows sum to 20·800 cycles; `busy` drops after code 9.
- Invalid code: `scen_sel`=1, then `scen_sel`=12 → `err` pulse each time, `start` never asserts, `busy` stays 0.
- Edge cases:
  - Reset in the middle of the second `start` cycle → `start`=0 and `busy`=0 after that edge.
  - `go` during WAIT → ignored.
  - `bus_done` coincident with counter expiry → `timeout`=0.
